// File: rtl/instruction_fetch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instruction_fetch_pkg: ISA field positions and type codes            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package instruction_fetch_pkg;

    // Field positions are shared with the control unit.
    localparam int TYPE_MSB = 31;
    localparam int TYPE_LSB = 29;
    localparam int OP_MSB   = 28;
    localparam int OP_LSB   = 24;

    typedef enum logic [2:0] {
        TYPE_BRANCH = 3'b000,
        TYPE_ALU    = 3'b001,
        TYPE_CONST  = 3'b010,
        TYPE_MEM    = 3'b100,
        TYPE_JUMP   = 3'b110
    } instr_type_e;

endpackage : instruction_fetch_pkg
`default_nettype wire

// File: rtl/instruction_fetch_pc_register.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pc_register: program counter, first-fetch flag and next-PC select    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pc_register #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_link
);

    logic              first;
    logic [ADDR_W-1:0] nxt;

    assign pc_link = pc + ADDR_W'(1);

    // The first fetch after reset always goes to RESET_PC regardless of branch inputs.
    always_comb begin
        nxt = pc_link;
        if (first) begin
            nxt = RESET_PC;
        end else if (br_taken) begin
            nxt = br_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= RESET_PC;
            first <= 1'b1;
        end else if (load) begin
            pc    <= nxt;
            first <= 1'b0;
        end
    end

endmodule : pc_register
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | instruction_fetch: PC, IR and req/ack fetch from instruction memory  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                MAX_WAIT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               w_pc,
    input  logic               br_taken,
    input  logic [ADDR_W-1:0]  br_target,
    output logic               im_req,
    output logic [ADDR_W-1:0]  im_addr,
    input  logic [INSTR_W-1:0] im_rdata,
    input  logic               im_ack,
    output logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W-1:0]  pc_link,
    output logic [INSTR_W-1:0] instr,
    output logic [2:0]         instr_type,
    output logic [4:0]         op,
    output logic               valid,
    output logic               busy,
    output logic               fault
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_REQ  = 1'b1;

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             load;

    assign load = (state == S_IDLE) && w_pc;

    pc_register #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_register (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .br_taken  (br_taken),
        .br_target (br_target),
        .pc        (pc),
        .pc_link   (pc_link)
    );

    // The request address is the PC itself: both load on the same edge and hold through REQ.
    assign im_addr    = pc;
    assign im_req     = (state == S_REQ);
    assign busy       = (state == S_REQ);
    assign instr_type = instr[TYPE_MSB:TYPE_LSB];
    assign op         = instr[OP_MSB:OP_LSB];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            instr <= '0;
            valid <= 1'b0;
            fault <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (w_pc) begin
                        state <= S_REQ;
                        cnt   <= '0;
                    end
                end
                S_REQ: begin
                    // A strobe while a fetch is outstanding is an overrun and is dropped.
                    if (w_pc) begin
                        fault <= 1'b1;
                    end
                    if (im_ack) begin
                        instr <= im_rdata;
                        valid <= 1'b1;
                        state <= S_IDLE;
                    end else if (cnt == CNT_W'(MAX_WAIT)) begin
                        fault <= 1'b1;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule : instruction_fetch
`default_nettype wire
